// File: rtl/neopix_frame_sequencer_if.sv
// Pixel stream handshake between the frame sequencer and the WS2812 serializer.
// The master presents pix/pix_valid; the slave answers with pix_ready.
interface neopix_frame_sequencer_if #(
    parameter int PIX_W = 24
);
    logic [PIX_W-1:0] pix;
    logic             pix_valid;
    logic             pix_ready;

    modport master (output pix, output pix_valid, input pix_ready);
    modport slave  (input pix, input pix_valid, output pix_ready);
endinterface

// File: rtl/neopix_frame_sequencer.sv
// Streams pixels 0..N-1 from the pixel RAM into the serializer through a
// small prefetch FIFO that covers the RAM read latency, then holds the latch gap.
module neopix_frame_sequencer #(
    parameter int ADDR_W    = 9,
    parameter int PIX_W     = 24,
    parameter int RD_LAT    = 2,
    parameter int FIFO_D    = 4,
    parameter int LATCH_CYC = 4000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   num_pix_i,
    output logic [ADDR_W-1:0] rdaddr_o,
    input  logic [PIX_W-1:0]  rd_data_i,
    neopix_frame_sequencer_if.master pix_if,
    output logic              latch_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int FC_W  = $clog2(FIFO_D + 1);
    localparam int CR_W  = $clog2(FIFO_D + RD_LAT + 1);
    localparam int GAP_W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
    localparam logic [CNT_W-1:0] MAX_PIX  = CNT_W'(1 << ADDR_W);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_D - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(LATCH_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_n;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_sent_cnt;
    logic [CNT_W-1:0]  w_n_sel;
    logic [ADDR_W-1:0] r_rdaddr;
    logic [GAP_W-1:0]  r_gap;
    logic [RD_LAT-1:0] r_vpipe;
    logic [PIX_W-1:0]  r_mem [FIFO_D];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FC_W-1:0]   r_fifo_cnt;
    logic [CR_W-1:0]   w_inflight;
    logic [CR_W-1:0]   w_credit;
    logic              w_start;
    logic              w_issue;
    logic              w_push;
    logic              w_valid;
    logic              w_pop;
    logic              w_last;
    logic              w_gap_load;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CR_W'(r_vpipe[i]);
        end
    end

    // Reads in flight count against FIFO space, so every return has a slot.
    assign w_credit   = CR_W'(r_fifo_cnt) + w_inflight;
    assign w_n_sel    = (num_pix_i > MAX_PIX) ? MAX_PIX : num_pix_i;
    assign w_start    = (r_state == S_IDLE) && start_i;
    assign w_issue    = (r_state == S_FETCH) && (r_rd_cnt < r_n)
                        && (w_credit < CR_W'(FIFO_D));
    assign w_push     = r_vpipe[RD_LAT-1];
    assign w_valid    = (r_state == S_FETCH) && (r_fifo_cnt != '0);
    assign w_pop      = w_valid && pix_if.pix_ready;
    assign w_last     = w_pop && (r_sent_cnt == r_n - CNT_W'(1));
    assign w_gap_load = (w_start && (w_n_sel == '0)) || w_last;

    assign rdaddr_o         = r_rdaddr;
    assign pix_if.pix_valid = w_valid;
    assign pix_if.pix       = w_valid ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        w_state_nxt = r_state;
        latch_o     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (w_n_sel == '0) ? S_LATCH : S_FETCH;
                end
            end
            S_FETCH: begin
                busy_o = 1'b1;
                if (w_last) w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                busy_o  = 1'b1;
                latch_o = 1'b1;
                if (r_gap == '0) begin
                    done_o      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_rd_cnt   <= '0;
            r_sent_cnt <= '0;
            r_rdaddr   <= '0;
            r_gap      <= '0;
            r_vpipe    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vpipe <= (r_vpipe << 1) | RD_LAT'(w_issue);
            if (w_start) begin
                r_n        <= w_n_sel;
                r_rd_cnt   <= '0;
                r_sent_cnt <= '0;
            end else begin
                if (w_issue) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                if (w_pop) r_sent_cnt <= r_sent_cnt + CNT_W'(1);
            end
            if (w_issue) r_rdaddr <= r_rd_cnt[ADDR_W-1:0];
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            unique case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + FC_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - FC_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_gap_load) begin
                r_gap <= GAP_LOAD;
            end else if ((r_state == S_LATCH) && (r_gap != '0)) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= rd_data_i;
    end
endmodule

// File: tb/tb_neopix_frame_sequencer.sv
// Bench for neopix_frame_sequencer: a vector table of frames plus reset and
// random frames, scored against a pixel-list model of the RAM contents.
module tb_neopix_frame_sequencer;
    localparam int LATCH = 4000;
    localparam int FD    = 4;
    localparam int LAT   = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [9:0]  num_pix_i;
    logic [8:0]  rdaddr_o;
    logic [23:0] rd_data_i;
    logic        latch_o;
    logic        busy_o;
    logic        done_o;
    logic [23:0] mem [512];

    int checks = 0;
    int errors = 0;

    neopix_frame_sequencer_if #(.PIX_W(24)) pif ();

    neopix_frame_sequencer dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .num_pix_i (num_pix_i),
        .rdaddr_o  (rdaddr_o),
        .rd_data_i (rd_data_i),
        .pix_if    (pif.master),
        .latch_o   (latch_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM output register; the address register is the sequencer's rdaddr_o
    always @(posedge clk_i) rd_data_i <= mem[rdaddr_o];

    typedef struct {
        int num;
        int pct;
        int mode;
        int ramk;
        int exp_n;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // mode 0 plain, 1 extra start pulses mid-frame, 2 ready low for 50 clocks
    task automatic run_frame(input int num, input int pct, input int mode,
                             input int ramk, input int exp_n);
        logic [23:0] expq[$];
        int cyc, got, pix_err, stall_err, latch_cnt, done_cnt;
        int first_v, last_v, max_addr, hold_err, done_at, budget;
        logic pv, pr;
        logic [23:0] pp;
        bit fin;
        for (int i = 0; i < 512; i++) begin
            mem[i] = (ramk == 0) ? 24'(i * 32'h010101) : 24'($urandom);
        end
        for (int i = 0; i < exp_n; i++) expq.push_back(mem[i]);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        num_pix_i = 10'(num);
        pif.pix_ready = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        pif.pix_ready = (mode == 2) ? 1'b0 : ($urandom_range(99) < pct);
        cyc = 0; got = 0; pix_err = 0; stall_err = 0; latch_cnt = 0;
        done_cnt = 0; first_v = -1; last_v = -1; max_addr = 0;
        hold_err = 0; done_at = -1; fin = 0;
        pv = 1'b0; pr = 1'b0; pp = '0;
        budget = exp_n * 40 + LATCH + 300;
        while (!fin) begin
            @(negedge clk_i);
            if (pv && !pr && !(pif.pix_valid && pif.pix == pp)) stall_err++;
            if (pif.pix_valid && first_v < 0) first_v = cyc;
            if (pif.pix_valid && pif.pix_ready) begin
                got++;
                last_v = cyc;
                if (expq.size() == 0) pix_err++;
                else if (pif.pix !== expq.pop_front()) pix_err++;
            end
            if (busy_o && cyc >= 1 && int'(rdaddr_o) > max_addr)
                max_addr = int'(rdaddr_o);
            if (latch_o) latch_cnt++;
            if (done_o) done_cnt++;
            if (mode == 2 && cyc >= 10 && cyc < 50 && rdaddr_o != 9'(FD - 1))
                hold_err++;
            pv = pif.pix_valid;
            pr = pif.pix_ready;
            pp = pif.pix;
            if (done_o && done_at < 0) done_at = cyc;
            if (done_at >= 0 && cyc == done_at + 3) fin = 1;
            if (cyc > budget) begin
                checks++;
                errors++;
                $display("FAIL frame timeout: got no done after %0d cycles", cyc);
                fin = 1;
            end
            @(posedge clk_i); #1;
            cyc++;
            pif.pix_ready = (mode == 2 && cyc < 50) ? 1'b0
                            : ($urandom_range(99) < pct);
            start_i = (mode == 1) && (cyc == 6 || latch_cnt == 100);
        end
        start_i = 1'b0;
        chk("pixel count", got, exp_n);
        chk("pixel data errors", pix_err, 0);
        chk("stall stability errors", stall_err, 0);
        chk("latch length", latch_cnt, LATCH);
        chk("done pulses", done_cnt, 1);
        chk("busy after done", busy_o, 0);
        if (exp_n > 0) begin
            chk("first pixel latency", first_v, LAT + 1);
            chk("last read address", max_addr, exp_n - 1);
            if (mode == 0 && pct == 100)
                chk("full-rate span", last_v - first_v, exp_n - 1);
        end else begin
            chk("empty frame first valid", first_v, -1);
        end
        if (mode == 2) chk("address hold under stall", hold_err, 0);
    endtask

    initial begin
        int got, k, dcnt, num, en;
        rst_n_i = 1'b0;
        start_i = 1'b0;
        num_pix_i = '0;
        pif.pix_ready = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        vecs[0] = '{3, 100, 0, 0, 3};
        vecs[1] = '{512, 50, 0, 1, 512};
        vecs[2] = '{700, 100, 0, 1, 512};
        vecs[3] = '{0, 100, 0, 1, 0};
        vecs[4] = '{20, 70, 1, 1, 20};
        vecs[5] = '{20, 100, 2, 1, 20};
        vecs[6] = '{1023, 80, 0, 0, 512};
        vecs[7] = '{1, 30, 0, 1, 1};
        #23;
        chk("reset outputs",
            {rdaddr_o, pif.pix, pif.pix_valid, latch_o, busy_o, done_o}, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].num, vecs[v].pct, vecs[v].mode,
                      vecs[v].ramk, vecs[v].exp_n);
        end

        for (int r = 0; r < 2; r++) begin
            num = int'($urandom_range(600, 0));
            en = (num > 512) ? 512 : num;
            run_frame(num, int'($urandom_range(100, 20)), 0, 1, en);
        end

        for (int i = 0; i < 512; i++) mem[i] = 24'($urandom);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        num_pix_i = 10'd200;
        pif.pix_ready = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        got = 0;
        k = 0;
        while (got < 100 && k < 1000) begin
            @(negedge clk_i);
            if (pif.pix_valid && pif.pix_ready) got++;
            k++;
        end
        chk("pixels before reset", got, 100);
        @(posedge clk_i); #3;
        rst_n_i = 1'b0;
        #1;
        chk("async reset outputs",
            {rdaddr_o, pif.pix, pif.pix_valid, latch_o, busy_o, done_o}, 0);
        dcnt = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) dcnt++;
        end
        chk("no done in reset", dcnt, 0);
        rst_n_i = 1'b1;
        run_frame(200, 100, 0, 1, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
